// File: rtl/bit_deposit32.sv
// Bit-addressable 32-bit register with single-bit writes and a 32-cycle LSB-first serial fill.
// Latency: writes visible the cycle after acceptance; a burst is 32 BURST cycles plus one DONE cycle.
// Backpressure: wr_ready is high only in IDLE; optional sync clear via BIT_DEPOSIT32_CLR_EN.
module bit_deposit32 (
    input  logic        clk,
    input  logic        rst_n,
`ifdef BIT_DEPOSIT32_CLR_EN
    input  logic        clr,
`endif
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_sel,
    input  logic        wr_bit,
    input  logic        burst_start,
    input  logic        ser_bit,
    output logic [31:0] q,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state;
    logic [4:0] cnt;
    logic       clr_hit;

`ifdef BIT_DEPOSIT32_CLR_EN
    assign clr_hit = clr;
`else
    assign clr_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else if (clr_hit) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A coincident single write lands now; serial writes start next edge.
                    if (wr_valid) q[wr_sel] <= wr_bit;
                    if (burst_start) begin
                        state <= BURST;
                        cnt   <= '0;
                    end
                end
                BURST: begin
                    q[cnt] <= ser_bit;
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign wr_ready = (state == IDLE);
    assign busy     = (state == BURST);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_bit_deposit32.sv
// Directed-plus-random bench for bit_deposit32 against a word-level reference model.
module tb_bit_deposit32;

    logic        clk = 1'b0;
    logic        rst_n;
`ifdef BIT_DEPOSIT32_CLR_EN
    logic        clr;
`endif
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_sel;
    logic        wr_bit;
    logic        burst_start;
    logic        ser_bit;
    logic [31:0] q;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q;

    bit_deposit32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef BIT_DEPOSIT32_CLR_EN
        .clr         (clr),
`endif
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_sel      (wr_sel),
        .wr_bit      (wr_bit),
        .burst_start (burst_start),
        .ser_bit     (ser_bit),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_write(input logic [4:0] sel, input logic b);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_bit   = b;
        tick();
        wr_valid = 1'b0;
        exp_q[sel] = b;
    endtask

    // Full burst of 'word'; optional coincident write at start and stray writes during the fill.
    task automatic run_burst(input logic [31:0] word, input bit coincide, input bit inject);
        int busy_cycles;
        burst_start = 1'b1;
        if (coincide) begin
            wr_valid = 1'b1;
            wr_sel   = 5'd31;
            wr_bit   = 1'b1;
            exp_q[31] = 1'b1;
        end
        tick();
        burst_start = 1'b0;
        wr_valid    = 1'b0;
        if (coincide) check("coincident_write", q, exp_q);
        busy_cycles = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy) busy_cycles++;
            check("burst_wr_ready", {31'd0, wr_ready}, 32'd0);
            ser_bit = word[i];
            burst_start = $urandom_range(0, 1) != 0;
            if (inject && i >= 8 && i <= 12) begin
                wr_valid = 1'b1;
                wr_sel   = 5'd3;
                wr_bit   = 1'b1;
            end
            tick();
            wr_valid = 1'b0;
        end
        burst_start = 1'b0;
        check("busy_cycles", busy_cycles, 32);
        check("done_pulse", {30'd0, busy, done}, 32'd1);
        exp_q = word;
        tick();
        check("after_done", {29'd0, done, busy, wr_ready}, 32'd1);
        check("burst_q", q, exp_q);
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  s;
        logic        b;
        rst_n = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_bit = 1'b0;
        burst_start = 1'b0; ser_bit = 1'b0;
`ifdef BIT_DEPOSIT32_CLR_EN
        clr = 1'b0;
`endif
        exp_q = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_q", q, 32'h0);
        check("reset_flags", {29'd0, done, busy, wr_ready}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        single_write(5'd0, 1'b1);
        single_write(5'd31, 1'b1);
        check("single_8000_0001", q, 32'h8000_0001);
        single_write(5'd0, 1'b0);
        check("single_8000_0000", q, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            s = 5'($urandom_range(0, 31));
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0; wr_sel = s; wr_bit = b;
                tick();
            end else begin
                single_write(s, b);
            end
            check("random_single", q, exp_q);
        end

        run_burst(32'hA5A5_F00F, 1'b0, 1'b0);

        w = $urandom & 32'hFFFF_FFF7;
        run_burst(w, 1'b0, 1'b1);
        check("bit3_serial_only", {31'd0, q[3]}, 32'd0);
        run_burst($urandom, 1'b0, 1'b0);

        // Return to q=0 via reset, then coincident write + all-zero burst.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_q = '0;
        check("reset_clears_q", q, 32'h0);
        tick();
        run_burst(32'h0, 1'b1, 1'b0);
        check("coincide_final_zero", q, 32'h0);

        single_write(5'd7, 1'b1);
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ser_bit = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midburst_rst_q", q, 32'h0);
        check("midburst_rst_flags", {29'd0, done, busy, wr_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        exp_q = '0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) check("no_resume_after_rst", {30'd0, busy, done}, 32'd0);
            tick();
        end
        check("post_rst_idle", {29'd0, done, busy, wr_ready}, 32'd1);
        single_write(5'd12, 1'b1);
        check("post_rst_write", q, exp_q);

`ifdef BIT_DEPOSIT32_CLR_EN
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ser_bit = 1'b1;
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q = '0;
        check("clr_q", q, 32'h0);
        check("clr_idle", {29'd0, done, busy, wr_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (done) check("clr_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        single_write(5'd9, 1'b1);
        wr_valid = 1'b1; wr_sel = 5'd20; wr_bit = 1'b1; clr = 1'b1;
        tick();
        wr_valid = 1'b0; clr = 1'b0;
        exp_q = '0;
        check("clr_overrides_write", q, exp_q);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_deposit32.md
BIT_DEPOSIT32 -- requirements
Module: bit_deposit32

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port wr_valid, input, 1, single-bit write request.
REQ-004 SHALL have port wr_ready, output, 1, single-bit write accept.
REQ-005 SHALL have port wr_sel, input, 5, target bit index for a single write.
REQ-006 SHALL have port wr_bit, input, 1, data for a single write.
REQ-007 SHALL have port burst_start, input, 1, request for a 32-bit serial fill.
REQ-008 SHALL have port ser_bit, input, 1, serial fill data, LSB first.
REQ-009 SHALL have port q, output, 32, stored word (bit i is the value a 32:1 select with index i returns).
REQ-010 SHALL have port busy, output, 1, high while a burst is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after a burst completes.

Function
REQ-012 SHALL implement FSM states IDLE, BURST and DONE, encoded in 2 bits.
REQ-013 SHALL drive wr_ready=1 only in IDLE.
REQ-014 SHALL, on wr_valid&&wr_ready at a clk edge, set q[wr_sel]<=wr_bit and leave the other 31 bits unchanged, visible the next cycle.
REQ-015 SHALL ignore wr_valid outside IDLE, with no write and no queuing.
REQ-016 SHALL, on burst_start in IDLE, go to BURST with the 5-bit counter cnt=0; burst_start is ignored in BURST and DONE.
REQ-017 SHALL, when burst_start and an accepted single write coincide in IDLE, apply the single write that edge and begin serial writes on the following edge.
REQ-018 SHALL, each BURST cycle, write q[cnt]<=ser_bit and increment cnt.
REQ-019 SHALL, at cnt==31, perform the final write and go to DONE; a burst takes exactly 32 BURST cycles.
REQ-020 SHALL keep cnt from wrapping; the transition out of BURST happens at 31.
REQ-021 SHALL drive busy=1 exactly in BURST.
REQ-022 SHALL drive done=1 exactly in DONE (one cycle), then go unconditionally to IDLE.
REQ-023 SHALL register all outputs or decode them from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, with rst_n low (asynchronous, any state including mid-burst), force q=32'h0000_0000, state=IDLE, cnt=0, busy=0, done=0 and wr_ready=1.
REQ-025 SHALL resume normal operation on the first clk edge after rst_n deasserts, with an aborted burst not resumed.

Configuration
REQ-026 SHALL, when macro BIT_DEPOSIT32_CLR_EN is defined, add input clr (1 bit, synchronous), where clr=1 at an edge sets q=0, state=IDLE and cnt=0 and overrides every other write, including mid-burst with no done pulse.
REQ-027 SHALL, when BIT_DEPOSIT32_CLR_EN is undefined, omit port clr, with behaviour as REQ-012..023.

Verification
REQ-028 SHALL test single writes: after reset, write sel=0 bit=1, then sel=31 bit=1, then q==32'h8000_0001; then write sel=0 bit=0, then q==32'h8000_0000.
REQ-029 SHALL test a burst: burst_start, then ser_bit stream for 32'hA5A5_F00F LSB first, giving busy high for 32 cycles, done high for 1 cycle, then q==32'hA5A5_F00F and wr_ready==1.
REQ-030 SHALL test writes during a burst: wr_valid sel=3 bit=1 during the burst, with wr_ready==0 and bit 3 equal to the serial value only.
REQ-031 SHALL test the simultaneous event: from q=0, wr_valid sel=31 bit=1 with burst_start in the same cycle and ser_bit all 0, giving q==32'h0000_0000 after done (the burst overwrites bit 31).
REQ-032 SHALL test reset mid-burst: rst_n low at burst cycle 10, giving q==0, busy==0 and done==0 immediately (asynchronously), and no done pulse afterward.
REQ-033 SHALL test clear, with BIT_DEPOSIT32_CLR_EN defined: clr at burst cycle 5 gives q==0, state IDLE and no done pulse; without the macro, port clr is absent.
